spi_frame_rx: RTL and testbench
===============================

Name: spi_frame_rx

Overview:
- Receive-side counterpart of the chip-select window and sample-strobe generators.
- While a chip-select window is open, samples a serial data line on each one-cycle strobe and assembles WIDTH bits into a parallel word.
- Presents each complete word on a valid/ready handshake to the delay core's sample path.
- Sits between the ADC serial pins and the sample FIFO/delay-line writer.

Parameters:
WIDTH, 12, bits per frame; legal range 2..32.
MSB_FIRST, 1, 1 = first captured bit lands in data[WIDTH-1]; 0 = first bit lands in data[0].

Ports:
clk  in  1  system clock; all state updates on posedge.
nrst  in  1  asynchronous, active-low reset.
cs  in  1  frame window, active high, synchronous to clk.
strobe  in  1  one-cycle sample pulse, synchronous to clk.
sdi  in  1  serial data, sampled on cycles where strobe=1.
data  out  WIDTH  last committed word.
valid  out  1  data holds an unconsumed word.
ready  in  1  consumer accepts data on an edge where valid=1 and ready=1.
busy  out  1  high in every state except IDLE.
overrun  out  1  sticky; set when a completed word is dropped.

Behaviour:
- Reset (nrst=0, asynchronous): state=IDLE; data=0; valid=0; overrun=0; shift register=0; bit count=0; cs_q=0.
- Edge detect: cs_q is the registered cs. Frame start = cs & ~cs_q.
- State IDLE:
  - On frame start, go to SHIFT and clear the bit count.
  - A strobe in the frame-start cycle is ignored.
  - Strobes with cs=0 are ignored.
- State SHIFT, cs=1 and strobe=1:
  - Shift sdi in and increment the count.
  - MSB_FIRST=1: shreg = {shreg[WIDTH-2:0], sdi}.
  - MSB_FIRST=0: shreg = {sdi, shreg[WIDTH-1:1]}.
  - When the WIDTH-th bit is captured, go to COMMIT.
- State SHIFT, cs=0 (short frame): discard the partial word, go to IDLE. data, valid and overrun are unchanged.
- State COMMIT (exactly one cycle):
  - If valid=0, or valid=1 and ready=1 on this edge: data <= shreg, valid <= 1.
  - If valid=1 and ready=0: the new word is dropped, data keeps the old word, overrun <= 1.
  - Next state is WAIT_LOW.
- State WAIT_LOW: extra strobes are ignored; when cs=0, go to IDLE.
- Back-to-back frames: a new frame needs cs low for at least one cycle.
- Latency: if the WIDTH-th strobe is in cycle n, valid and the new data are visible from cycle n+2.
- Handshake:
  - valid clears on the edge after valid & ready.
  - If a commit falls on that same edge, valid stays 1 and data updates; this is not an overrun.
  - data is stable while valid=1 and ready=0.
- Count width is $clog2(WIDTH+1). No wrap is possible, because the count stops at WIDTH.
- Only reset clears overrun.
- Reset mid-frame: immediate return to reset values. A frame still active when reset is released is ignored until cs goes low and then high again.

Optional Feature:
Macro SPI_FRAME_RX_ERR_EN.
- Defined:
  - Adds output port frame_err (1 bit, reset 0).
  - frame_err pulses high for exactly one cycle on the edge after a short-frame abort (SHIFT exited with count < WIDTH).
  - frame_err also pulses for a frame start with cs falling before any strobe.
- Not defined:
  - No frame_err port.
  - Short frames are silently discarded.
- All other behaviour is identical in both builds.

Test Plan:
- Directed stimulus uses WIDTH=12, MSB_FIRST=1, ready=1.
- Normal frame: cs high for 12 strobes, sdi bits 1010_0011_1100 → data=12'hA3C; valid high from the cycle 2 after the last strobe, for one cycle; busy=0 after cs falls.
- LSB-first build (MSB_FIRST=0), same bit sequence → data=12'h3C5.
- Overrun: ready=0; send 12'h123, then 12'hABC → data stays 12'h123 and overrun=1. Raise ready → valid clears next cycle; overrun stays 1.
- Commit coincident with accept: hold valid with 12'h111; raise ready on exactly the COMMIT edge of 12'h222 → valid stays 1, data=12'h222, overrun=0.
- Short frame: cs falls after 7 strobes → data and valid unchanged. With SPI_FRAME_RX_ERR_EN defined, frame_err is high for one cycle. Next full frame with 12'h5A5 → 12'h5A5.
- Reset: assert nrst low asynchronously mid-SHIFT, between clock edges → all outputs 0 immediately. Release while cs=1 with strobes → no word captured until cs toggles low then high.

Source files
------------

// File: rtl/spi_frame_rx_if.sv
// spi_frame_rx_if: parallel word handshake between the frame receiver
// and the sample-path consumer.
interface spi_frame_rx_if #(
  parameter int WIDTH = 12
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (
    output data,
    output valid,
    input  ready
  );

  modport slave (
    input  data,
    input  valid,
    output ready
  );
endinterface

// File: rtl/spi_frame_rx.sv
// spi_frame_rx: strobe-sampled serial-to-parallel frame receiver.
// Define SPI_FRAME_RX_ERR_EN to add the frame_err short-frame pulse.
module spi_frame_rx #(
  parameter int WIDTH     = 12,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic clk,
  input  logic nrst,
  input  logic cs,
  input  logic strobe,
  input  logic sdi,
  spi_frame_rx_if.master bus,
  output logic busy,
  output logic overrun
`ifdef SPI_FRAME_RX_ERR_EN
  ,
  output logic frame_err
`endif
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    COMMIT,
    WAIT_LOW
  } state_t;

  state_t           state;
  state_t           state_n;
  logic             cs_q;
  logic             armed;
  logic             start;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] shreg_n;
  logic [WIDTH-1:0] data_q;
  logic             valid_q;
  logic             shift_en;
  logic             commit;
  logic             abort;

  // armed blocks a frame already open when reset is released
  assign start = cs & ~cs_q & armed;

  assign shreg_n = MSB_FIRST ? {shreg[WIDTH-2:0], sdi}
                             : {sdi, shreg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n  = state;
    shift_en = 1'b0;
    commit   = 1'b0;
    abort    = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_n = SHIFT;
      end
      SHIFT: begin
        if (!cs) begin
          abort   = 1'b1;
          state_n = IDLE;
        end else if (strobe) begin
          shift_en = 1'b1;
          if (cnt == LAST) state_n = COMMIT;
        end
      end
      COMMIT: begin
        commit  = 1'b1;
        state_n = WAIT_LOW;
      end
      WAIT_LOW: begin
        if (!cs) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      cs_q    <= 1'b0;
      armed   <= 1'b0;
      cnt     <= '0;
      shreg   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      overrun <= 1'b0;
    end else begin
      cs_q <= cs;
      if (!cs) armed <= 1'b1;
      if ((state == IDLE && start) || abort) begin
        cnt <= '0;
      end else if (shift_en) begin
        cnt <= cnt + 1'b1;
      end
      if (shift_en) shreg <= shreg_n;
      if (commit) begin
        if (!valid_q || bus.ready) begin
          data_q  <= shreg;
          valid_q <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid_q && bus.ready) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef SPI_FRAME_RX_ERR_EN
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      frame_err <= 1'b0;
    end else begin
      frame_err <= abort;
    end
  end
`endif

  assign bus.data  = data_q;
  assign bus.valid = valid_q;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_spi_frame_rx.sv
// tb_spi_frame_rx: directed checks of the frame receiver, MSB-first
// main instance plus an LSB-first instance on the same serial inputs.
module tb_spi_frame_rx;

  logic clk;
  logic nrst;
  logic cs;
  logic strobe;
  logic sdi;
  logic busy;
  logic overrun;
  logic busy_l;
  logic overrun_l;
`ifdef SPI_FRAME_RX_ERR_EN
  logic frame_err;
  logic frame_err_l;
`endif

  int checks;
  int failures;

  spi_frame_rx_if #(.WIDTH(12)) bus ();
  spi_frame_rx_if #(.WIDTH(12)) bus_l ();

  spi_frame_rx #(.WIDTH(12), .MSB_FIRST(1'b1)) dut (
    .clk       (clk),
    .nrst      (nrst),
    .cs        (cs),
    .strobe    (strobe),
    .sdi       (sdi),
    .bus       (bus),
    .busy      (busy),
    .overrun   (overrun)
`ifdef SPI_FRAME_RX_ERR_EN
    ,
    .frame_err (frame_err)
`endif
  );

  spi_frame_rx #(.WIDTH(12), .MSB_FIRST(1'b0)) dut_l (
    .clk       (clk),
    .nrst      (nrst),
    .cs        (cs),
    .strobe    (strobe),
    .sdi       (sdi),
    .bus       (bus_l),
    .busy      (busy_l),
    .overrun   (overrun_l)
`ifdef SPI_FRAME_RX_ERR_EN
    ,
    .frame_err (frame_err_l)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Opens cs, then sends n bits MSB of w first with a gap cycle between
  // strobes; returns in the cycle right after the last strobe, cs high.
  task automatic send_bits(input logic [11:0] w, input int n);
    cs = 1'b1;
    tick();
    for (int i = 0; i < n; i++) begin
      strobe = 1'b1;
      sdi    = w[11-i];
      tick();
      strobe = 1'b0;
      sdi    = 1'b0;
      if (i < n - 1) tick();
    end
  endtask

  task automatic full_frame(input logic [11:0] w);
    send_bits(w, 12);
    tick();
    cs = 1'b0;
    tick();
  endtask

  task automatic apply_reset();
    nrst = 1'b0;
    tick();
    tick();
    nrst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    cs = 1'b0; strobe = 1'b0; sdi = 1'b0;
    bus.ready = 1'b1; bus_l.ready = 1'b1;
    apply_reset();
    checks++;
    if (bus.data !== 12'h000) begin
      failures++; $display("FAIL reset_data got=%h exp=000", bus.data);
    end
    checks++;
    if (bus.valid !== 1'b0) begin
      failures++; $display("FAIL reset_valid got=%b exp=0", bus.valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL reset_busy got=%b exp=0", busy);
    end
    checks++;
    if (overrun !== 1'b0) begin
      failures++; $display("FAIL reset_overrun got=%b exp=0", overrun);
    end
  endtask

  task automatic test_normal();
    bus.ready = 1'b1;
    send_bits(12'b1010_0011_1100, 12);
    checks++;
    if (bus.valid !== 1'b0) begin
      failures++; $display("FAIL normal_latency_n1 valid got=%b exp=0", bus.valid);
    end
    tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.data !== 12'hA3C) begin
      failures++;
      $display("FAIL normal_word valid=%b data=%h exp valid=1 data=a3c", bus.valid, bus.data);
    end
    checks++;
    if (bus_l.valid !== 1'b1 || bus_l.data !== 12'h3C5) begin
      failures++;
      $display("FAIL lsb_word valid=%b data=%h exp valid=1 data=3c5", bus_l.valid, bus_l.data);
    end
    checks++;
    if (busy !== 1'b1) begin
      failures++; $display("FAIL normal_busy_wait got=%b exp=1", busy);
    end
    cs = 1'b0;
    tick();
    checks++;
    if (bus.valid !== 1'b0) begin
      failures++; $display("FAIL normal_valid_pulse got=%b exp=0", bus.valid);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL normal_busy_idle got=%b exp=0", busy);
    end
  endtask

  task automatic test_overrun();
    bus.ready = 1'b0;
    full_frame(12'h123);
    checks++;
    if (bus.valid !== 1'b1 || bus.data !== 12'h123) begin
      failures++;
      $display("FAIL ovr_first valid=%b data=%h exp valid=1 data=123", bus.valid, bus.data);
    end
    full_frame(12'hABC);
    checks++;
    if (bus.data !== 12'h123) begin
      failures++; $display("FAIL ovr_data_held got=%h exp=123", bus.data);
    end
    checks++;
    if (overrun !== 1'b1) begin
      failures++; $display("FAIL ovr_flag got=%b exp=1", overrun);
    end
    bus.ready = 1'b1;
    tick();
    checks++;
    if (bus.valid !== 1'b0) begin
      failures++; $display("FAIL ovr_accept_valid got=%b exp=0", bus.valid);
    end
    checks++;
    if (overrun !== 1'b1) begin
      failures++; $display("FAIL ovr_sticky got=%b exp=1", overrun);
    end
  endtask

  task automatic test_coincident();
    apply_reset();
    bus.ready = 1'b0;
    full_frame(12'h111);
    send_bits(12'h222, 12);
    bus.ready = 1'b1;
    tick();
    bus.ready = 1'b0;
    checks++;
    if (bus.valid !== 1'b1 || bus.data !== 12'h222) begin
      failures++;
      $display("FAIL coin_word valid=%b data=%h exp valid=1 data=222", bus.valid, bus.data);
    end
    checks++;
    if (overrun !== 1'b0) begin
      failures++; $display("FAIL coin_overrun got=%b exp=0", overrun);
    end
    cs = 1'b0;
    tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.data !== 12'h222) begin
      failures++;
      $display("FAIL coin_hold valid=%b data=%h exp valid=1 data=222", bus.valid, bus.data);
    end
    bus.ready = 1'b1;
    tick();
  endtask

  task automatic test_short_frame();
    bus.ready = 1'b1;
    send_bits(12'hFFF, 7);
    cs = 1'b0;
    tick();
    checks++;
    if (bus.valid !== 1'b0 || bus.data !== 12'h222) begin
      failures++;
      $display("FAIL short_unchanged valid=%b data=%h exp valid=0 data=222", bus.valid, bus.data);
    end
    checks++;
    if (busy !== 1'b0) begin
      failures++; $display("FAIL short_busy got=%b exp=0", busy);
    end
`ifdef SPI_FRAME_RX_ERR_EN
    checks++;
    if (frame_err !== 1'b1) begin
      failures++; $display("FAIL short_err_pulse got=%b exp=1", frame_err);
    end
`endif
    tick();
`ifdef SPI_FRAME_RX_ERR_EN
    checks++;
    if (frame_err !== 1'b0) begin
      failures++; $display("FAIL short_err_one_cycle got=%b exp=0", frame_err);
    end
`endif
    send_bits(12'h5A5, 12);
    tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.data !== 12'h5A5) begin
      failures++;
      $display("FAIL short_next valid=%b data=%h exp valid=1 data=5a5", bus.valid, bus.data);
    end
    cs = 1'b0;
    tick();
  endtask

  task automatic test_mid_reset();
    bus.ready = 1'b0;
    full_frame(12'h0F1);
    send_bits(12'hFFF, 4);
    #3;
    nrst = 1'b0;
    #1;
    checks++;
    if (bus.data !== 12'h000 || bus.valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_async_word valid=%b data=%h exp valid=0 data=000", bus.valid, bus.data);
    end
    checks++;
    if (busy !== 1'b0 || overrun !== 1'b0) begin
      failures++; $display("FAIL rst_async_flags busy=%b ovr=%b exp 0 0", busy, overrun);
    end
    tick();
    nrst = 1'b1;
    bus.ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      strobe = 1'b1;
      sdi    = 1'b1;
      tick();
      strobe = 1'b0;
      tick();
    end
    tick();
    checks++;
    if (bus.valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_stale_frame valid=%b busy=%b exp 0 0", bus.valid, busy);
    end
    cs = 1'b0;
    tick();
    send_bits(12'hA3C, 12);
    tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.data !== 12'hA3C) begin
      failures++;
      $display("FAIL rst_rearm valid=%b data=%h exp valid=1 data=a3c", bus.valid, bus.data);
    end
    cs = 1'b0;
    tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    nrst     = 1'b1;
    test_reset();
    test_normal();
    test_overrun();
    test_coincident();
    test_short_frame();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
